// File: rtl/tick_ctrl_pkg.sv
// Shared types and default timing constants for the tick_ctrl front end.
package tick_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } tick_state_e;

   localparam int TICK_CYCLES_DEF     = 25_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/tick_ctrl_if.sv
// Board-side key/switch inputs and counter-side tick/running outputs of tick_ctrl.
// Optional macro TICK_CTRL_SPEED_EN adds the 2-bit speed select sw.
interface tick_ctrl_if;
   import tick_ctrl_pkg::*;

   // Keys and sw are raw asynchronous levels (no handshake); tick is a one-cycle
   // strobe the counter must accept unconditionally, so there is no ready.
   logic        key_run_n;
   logic        key_step_n;
`ifdef TICK_CTRL_SPEED_EN
   logic [1:0]  sw;
`endif
   logic        tick;
   logic        running;
   tick_state_e state;

   modport master (
`ifdef TICK_CTRL_SPEED_EN
      output sw,
`endif
      output key_run_n,
      output key_step_n,
      input  tick,
      input  running,
      input  state
   );

   modport slave (
`ifdef TICK_CTRL_SPEED_EN
      input  sw,
`endif
      input  key_run_n,
      input  key_step_n,
      output tick,
      output running,
      output state
   );

endinterface

// File: rtl/key_debounce.sv
// Push-button front end: 2-flop synchroniser, stability-count debounce and a
// one-cycle press pulse on the debounced falling edge.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync_m;
   logic          sync_s;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_m  <= 1'b1;
         sync_s  <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
      end else begin
         sync_m  <= key_n;
         sync_s  <= sync_m;
         level_d <= level;
         // Any agreement with the accepted level restarts the stability window.
         if (sync_s == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level_d & ~level;

endmodule

// File: rtl/tick_ctrl.sv
// Run/pause/step controller producing the counter advance strobe tick.
// Optional macro TICK_CTRL_SPEED_EN enables the sw speed divider (/1,/2,/4,/8).
module tick_ctrl
   import tick_ctrl_pkg::*;
#(
   parameter int TICK_CYCLES     = TICK_CYCLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input logic        clk,
   input logic        rst_n,
   tick_ctrl_if.slave bus
);

   localparam int PW = $clog2(TICK_CYCLES);

   logic          run_evt;
   logic          step_evt;
   tick_state_e   state;
   tick_state_e   state_next;
   logic [PW-1:0] p;
   logic [PW-1:0] p_next;
   logic [PW-1:0] term;
   logic          tick_q;
   logic          tick_next;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_run_n),
      .press (run_evt)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_step_n),
      .press (step_evt)
   );

`ifdef TICK_CTRL_SPEED_EN
   logic [1:0] sw_m;
   logic [1:0] sw_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_m <= 2'b00;
         sw_s <= 2'b00;
      end else begin
         sw_m <= bus.sw;
         sw_s <= sw_m;
      end
   end

   assign term = PW'((TICK_CYCLES >> sw_s) - 1);
`else
   assign term = PW'(TICK_CYCLES - 1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (run_evt) state_next = (state == RUN) ? PAUSE : RUN;
   end

   // A run event always wins: it clears the prescaler and swallows a same-cycle step.
   // Using >= lets a smaller sw terminal wrap p on the next cycle.
   always_comb begin
      p_next    = '0;
      tick_next = 1'b0;
      if (!run_evt) begin
         if (state == PAUSE) begin
            tick_next = step_evt;
         end else if (p >= term) begin
            tick_next = 1'b1;
         end else begin
            p_next = p + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p      <= '0;
         tick_q <= 1'b0;
      end else begin
         p      <= p_next;
         tick_q <= tick_next;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.running = (state == RUN);
   assign bus.state   = state;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl: reset, key debounce, pause/step, run-wins, async reset.
module tb_tick_ctrl;
  import tick_ctrl_pkg::*;

`ifdef TICK_CTRL_SPEED_EN
  localparam int TC = 64;
`else
  localparam int TC = 8;
`endif
  localparam int DC = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  tick_ctrl_if bus ();

  tick_ctrl #(.TICK_CYCLES(TC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_run_n = 1'b1;
    bus.key_step_n = 1'b1;
`ifdef TICK_CTRL_SPEED_EN
    bus.sw = 2'd0;
`endif
    cycn(3);
    tests++;
    if (bus.tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
    tests++;
    if (bus.running !== 1'b1) begin fails++; $display("FAIL reset_running got %b exp 1", bus.running); end
    tests++;
    if (bus.state !== RUN) begin fails++; $display("FAIL reset_state got %0d exp %0d", bus.state, RUN); end
    rst_n = 1'b1;
    for (int k = 1; k <= 3 * TC + 2; k++) begin
      cyc();
      tests++;
      if (bus.tick !== ((k % TC) == 0)) begin
        fails++;
        $display("FAIL run_period k=%0d got %b exp %b", k, bus.tick, ((k % TC) == 0));
      end
    end
    tests++;
    if (bus.running !== 1'b1) begin fails++; $display("FAIL run_running got %b exp 1", bus.running); end
  endtask

  task automatic test_pause_bounce();
    int lows[3];
    int highs[3];
    int n;
    lows = '{2, 1, 3};
    highs = '{2, 3, 2};
    for (int i = 0; i < 3; i++) begin
      bus.key_run_n = 1'b0;
      for (int j = 0; j < lows[i]; j++) begin
        cyc();
        tests++;
        if (bus.running !== 1'b1) begin fails++; $display("FAIL bounce_low i=%0d got %b exp 1", i, bus.running); end
      end
      bus.key_run_n = 1'b1;
      for (int j = 0; j < highs[i]; j++) begin
        cyc();
        tests++;
        if (bus.running !== 1'b1) begin fails++; $display("FAIL bounce_high i=%0d got %b exp 1", i, bus.running); end
      end
    end
    bus.key_run_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      tests++;
      if (bus.running !== (k < 7)) begin
        fails++;
        $display("FAIL pause_toggle k=%0d got %b exp %b", k, bus.running, (k < 7));
      end
      if (k >= 7) begin
        tests++;
        if (bus.tick !== 1'b0) begin fails++; $display("FAIL pause_tick k=%0d got %b exp 0", k, bus.tick); end
      end
    end
    bus.key_run_n = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (bus.tick === 1'b1) n++;
    end
    tests++;
    if (n != 0) begin fails++; $display("FAIL pause_release_ticks got %0d exp 0", n); end
    tests++;
    if (bus.running !== 1'b0) begin fails++; $display("FAIL pause_release_running got %b exp 0", bus.running); end
  endtask

  task automatic test_step_hold();
    int n;
    int first_k;
    int second_k;
    n = 0;
    first_k = -1;
    second_k = -1;
    bus.key_step_n = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (bus.tick === 1'b1) begin n++; if (first_k < 0) first_k = k; end
    end
    bus.key_step_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.tick === 1'b1) n++;
    end
    bus.key_step_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (bus.tick === 1'b1) begin n++; if (second_k < 0) second_k = k; end
    end
    bus.key_step_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.tick === 1'b1) n++;
    end
    tests++;
    if (n != 2) begin fails++; $display("FAIL step_count got %0d exp 2", n); end
    tests++;
    if (first_k != 7) begin fails++; $display("FAIL step_latency1 got %0d exp 7", first_k); end
    tests++;
    if (second_k != 7) begin fails++; $display("FAIL step_latency2 got %0d exp 7", second_k); end
    tests++;
    if (bus.running !== 1'b0) begin fails++; $display("FAIL step_running got %b exp 0", bus.running); end
  endtask

  task automatic test_run_step();
    int ks;
    logic exp_tick;
    ks = 7 + TC + TC / 2;
    bus.key_run_n = 1'b0;
    for (int k = 1; k <= 7 + 4 * TC + 2; k++) begin
      if (k == 11) bus.key_run_n = 1'b1;
      if (k == ks) bus.key_step_n = 1'b0;
      if (k == ks + 12) bus.key_step_n = 1'b1;
      cyc();
      exp_tick = (k > 7) && (((k - 7) % TC) == 0);
      tests++;
      if (bus.tick !== exp_tick) begin
        fails++;
        $display("FAIL run_step_tick k=%0d got %b exp %b", k, bus.tick, exp_tick);
      end
      tests++;
      if (bus.running !== (k >= 7)) begin
        fails++;
        $display("FAIL run_step_running k=%0d got %b exp %b", k, bus.running, (k >= 7));
      end
    end
  endtask

  task automatic test_both_keys();
    logic exp_tick;
    bus.key_run_n = 1'b0;
    cycn(10);
    bus.key_run_n = 1'b1;
    cycn(10);
    tests++;
    if (bus.running !== 1'b0) begin fails++; $display("FAIL both_prepause got %b exp 0", bus.running); end
    bus.key_run_n = 1'b0;
    bus.key_step_n = 1'b0;
    for (int k = 1; k <= 7 + 2 * TC + 2; k++) begin
      if (k == 11) begin
        bus.key_run_n = 1'b1;
        bus.key_step_n = 1'b1;
      end
      cyc();
      exp_tick = (k > 7) && (((k - 7) % TC) == 0);
      tests++;
      if (bus.tick !== exp_tick) begin
        fails++;
        $display("FAIL both_tick k=%0d got %b exp %b", k, bus.tick, exp_tick);
      end
      tests++;
      if (bus.running !== (k >= 7)) begin
        fails++;
        $display("FAIL both_running k=%0d got %b exp %b", k, bus.running, (k >= 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.key_run_n = 1'b0;
    cycn(7);
    tests++;
    if (bus.running !== 1'b0) begin fails++; $display("FAIL rmid_paused got %b exp 0", bus.running); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.running !== 1'b1) begin fails++; $display("FAIL rmid_async_running got %b exp 1", bus.running); end
    tests++;
    if (bus.state !== RUN) begin fails++; $display("FAIL rmid_async_state got %0d exp %0d", bus.state, RUN); end
    bus.key_run_n = 1'b1;
    cycn(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      tests++;
      if (bus.tick !== 1'b0) begin fails++; $display("FAIL rmid_pre k=%0d got %b exp 0", k, bus.tick); end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.tick !== 1'b0) begin fails++; $display("FAIL rmid_p5_tick got %b exp 0", bus.tick); end
    tests++;
    if (bus.running !== 1'b1) begin fails++; $display("FAIL rmid_p5_running got %b exp 1", bus.running); end
    cycn(2);
    rst_n = 1'b1;
    for (int k = 1; k <= TC; k++) begin
      cyc();
      tests++;
      if (bus.tick !== (k == TC)) begin
        fails++;
        $display("FAIL rmid_first k=%0d got %b exp %b", k, bus.tick, (k == TC));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.tick !== 1'b0) begin fails++; $display("FAIL rmid_cut_tick got %b exp 0", bus.tick); end
    cycn(2);
    rst_n = 1'b1;
    cycn(2);
  endtask

`ifdef TICK_CTRL_SPEED_EN
  task automatic test_speed();
    logic exp_tick;
    rst_n = 1'b0;
    bus.sw = 2'd3;
    cycn(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      tests++;
      if (bus.tick !== ((k % 8) == 0)) begin
        fails++;
        $display("FAIL speed_div8 k=%0d got %b exp %b", k, bus.tick, ((k % 8) == 0));
      end
    end
    rst_n = 1'b0;
    bus.sw = 2'd0;
    cycn(2);
    rst_n = 1'b1;
    cycn(20);
    bus.sw = 2'd3;
    for (int k = 21; k <= 40; k++) begin
      cyc();
      exp_tick = (k == 23) || (k == 31) || (k == 39);
      tests++;
      if (bus.tick !== exp_tick) begin
        fails++;
        $display("FAIL speed_switch k=%0d got %b exp %b", k, bus.tick, exp_tick);
      end
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.key_run_n = 1'b1;
    bus.key_step_n = 1'b1;
`ifdef TICK_CTRL_SPEED_EN
    bus.sw = 2'd0;
`endif
    test_reset();
    test_pause_bounce();
    test_step_hold();
    test_run_step();
    test_both_keys();
    test_reset_mid();
`ifdef TICK_CTRL_SPEED_EN
    test_speed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
